// File: rtl/regfile_mp.sv
// regfile_mp: parametrised 2R/1W register file, registered reads with write bypass
// and a one-entry-per-cycle bulk clear sequencer. Optional trace: REGFILE_TRACE_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_acc;
    logic              rd_acc;

    // Accepted accesses: nothing gets through while the clear runs,
    // and writes to the hard-wired zero entry are discarded.
    assign wr_acc = wr_en && !busy
                 && !(ZERO_REG && (wr_addr == '0));
    assign rd_acc = rd_en && !busy;

    // State and clear-counter register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: start clear from IDLE, walk every entry, then return
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from state: busy stalls decode during the clear
    always_comb begin
        busy = (state_q == CLEAR);
    end

    // Storage array: normal writes in IDLE, one zeroed entry per cycle in CLEAR
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_acc) begin
                mem_q[wr_addr] <= wr_data;
            end
            if (state_q == CLEAR) begin
                mem_q[cnt_q[ADDR_W-1:0]] <= '0;
            end
        end
    end

    // Read-port next values: zero entry, then same-edge write bypass, then array
    always_comb begin
        rd_data1_d = rd_data1_q;
        rd_data2_d = rd_data2_q;
        rd_valid_d = rd_acc;
        if (rd_acc) begin
            if (ZERO_REG && (rd_addr1 == '0)) begin
                rd_data1_d = '0;
            end else if (wr_acc && (wr_addr == rd_addr1)) begin
                rd_data1_d = wr_data;
            end else begin
                rd_data1_d = mem_q[rd_addr1];
            end
            if (ZERO_REG && (rd_addr2 == '0)) begin
                rd_data2_d = '0;
            end else if (wr_acc && (wr_addr == rd_addr2)) begin
                rd_data2_d = wr_data;
            end else begin
                rd_data2_d = mem_q[rd_addr2];
            end
        end
    end

    // Registered read data and valid flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
    assign rd_valid = rd_valid_q;

`ifdef REGFILE_TRACE_EN
    // Simulation trace of accepted writes and clear start/finish
    always @(posedge clock) begin
        if (resetn) begin
            if (wr_acc) begin
                $display("regfile_mp write addr=%0d data=%h", wr_addr, wr_data);
            end
            if ((state_q == IDLE) && (state_d == CLEAR)) begin
                $display("CLEAR start");
            end
            if ((state_q == CLEAR) && (state_d == IDLE)) begin
                $display("CLEAR done");
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: bench for regfile_mp with ZERO_REG=1, ZERO_REG=0 and a
// narrow 16x8 instance; scoreboard queues hold expected read data.
module tb_regfile_mp;

    logic        clock;
    logic        resetn;
    logic        rd_en;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        wr_en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        clr;

    logic [31:0] a_d1, a_d2, b_d1, b_d2;
    logic        a_v, a_busy, b_v, b_busy;

    logic        c_rd_en, c_wr_en, c_clr;
    logic [2:0]  c_a1, c_a2, c_wa;
    logic [15:0] c_wd, c_d1, c_d2;
    logic        c_v, c_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    typedef struct {
        logic        rd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] eb1;
    } vec_t;

    exp_t        qa[$];
    exp_t        qb[$];
    vec_t        tbl[10];
    logic [31:0] ma [32];
    logic [31:0] mb [32];
    logic        m_busy;
    int          m_cnt;
    logic        wacc_a, wacc_b;

    regfile_mp dut_a (
        .clock(clock), .resetn(resetn),
        .rd_en(rd_en), .rd_addr1(a1), .rd_addr2(a2),
        .rd_data1(a_d1), .rd_data2(a_d2), .rd_valid(a_v),
        .wr_en(wr_en), .wr_addr(wa), .wr_data(wd),
        .clr_req(clr), .busy(a_busy)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut_b (
        .clock(clock), .resetn(resetn),
        .rd_en(rd_en), .rd_addr1(a1), .rd_addr2(a2),
        .rd_data1(b_d1), .rd_data2(b_d2), .rd_valid(b_v),
        .wr_en(wr_en), .wr_addr(wa), .wr_data(wd),
        .clr_req(clr), .busy(b_busy)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) dut_c (
        .clock(clock), .resetn(resetn),
        .rd_en(c_rd_en), .rd_addr1(c_a1), .rd_addr2(c_a2),
        .rd_data1(c_d1), .rd_data2(c_d2), .rd_valid(c_v),
        .wr_en(c_wr_en), .wr_addr(c_wa), .wr_data(c_wd),
        .clr_req(c_clr), .busy(c_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] pred_a(input logic [4:0] ad);
        if (ad == 5'd0) return 32'd0;
        if (wacc_a && wa == ad) return wd;
        return ma[ad];
    endfunction

    function automatic logic [31:0] pred_b(input logic [4:0] ad);
        if (wacc_b && wa == ad) return wd;
        return mb[ad];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        m_busy = 1'b0;
        m_cnt  = 0;
        qa.delete();
        qb.delete();
    endtask

    task automatic step(input bit use_tbl, input logic [31:0] t1,
                        input logic [31:0] t2);
        logic racc;
        exp_t e;
        racc   = rd_en && !m_busy;
        wacc_a = wr_en && !m_busy && (wa != 5'd0);
        wacc_b = wr_en && !m_busy;
        if (racc) begin
            e.d1 = use_tbl ? t1 : pred_a(a1);
            e.d2 = use_tbl ? t2 : pred_a(a2);
            qa.push_back(e);
            e.d1 = pred_b(a1);
            e.d2 = pred_b(a2);
            qb.push_back(e);
        end
        @(posedge clock);
        if (wacc_a) ma[wa] = wd;
        if (wacc_b) mb[wa] = wd;
        if (m_busy) begin
            ma[m_cnt] = '0;
            mb[m_cnt] = '0;
            if (m_cnt == 31) m_busy = 1'b0;
            m_cnt++;
        end else if (clr) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end
        #1;
        chk("busy_a", {31'd0, a_busy}, {31'd0, m_busy});
        chk("busy_b", {31'd0, b_busy}, {31'd0, m_busy});
        chk("valid_a", {31'd0, a_v}, {31'd0, racc});
        if (racc && qa.size() > 0 && qb.size() > 0) begin
            e = qa.pop_front();
            chk("rd1_a", a_d1, e.d1);
            chk("rd2_a", a_d2, e.d2);
            e = qb.pop_front();
            chk("rd1_b", b_d1, e.d1);
            chk("rd2_b", b_d2, e.d2);
        end
    endtask

    task automatic idle_in();
        rd_en = 0; a1 = 0; a2 = 0;
        wr_en = 0; wa = 0; wd = 0; clr = 0;
    endtask

    initial begin
        int n;
        idle_in();
        c_rd_en = 0; c_wr_en = 0; c_clr = 0;
        c_a1 = 0; c_a2 = 0; c_wa = 0; c_wd = 0;
        wacc_a = 0; wacc_b = 0;
        model_reset();

        tbl[0] = '{1, 5, 31, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1] = '{0, 0, 0, 1, 8, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
        tbl[2] = '{1, 8, 8, 0, 0, 32'h0,
                   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[3] = '{1, 9, 8, 1, 9, 32'h12345678,
                   32'h12345678, 32'hDEADBEEF, 32'h12345678};
        tbl[4] = '{0, 0, 0, 1, 0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
        tbl[5] = '{1, 0, 9, 0, 0, 32'h0,
                   32'h0, 32'h12345678, 32'hFFFFFFFF};
        tbl[6] = '{1, 0, 0, 1, 0, 32'h55, 32'h0, 32'h0, 32'h55};
        tbl[7] = '{1, 31, 31, 1, 31, 32'hCAFEF00D,
                   32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[8] = '{0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[9] = '{1, 31, 5, 0, 0, 32'h0,
                   32'hCAFEF00D, 32'h0, 32'hCAFEF00D};

        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("rst_d1", a_d1, 32'h0);
        chk("rst_d2", a_d2, 32'h0);
        chk("rst_valid", {31'd0, a_v}, 32'h0);
        chk("rst_busy", {31'd0, a_busy}, 32'h0);
        #8 resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            rd_en = tbl[i].rd;
            a1    = tbl[i].ra1;
            a2    = tbl[i].ra2;
            wr_en = tbl[i].wr;
            wa    = tbl[i].waddr;
            wd    = tbl[i].wdata;
            step(1'b1, tbl[i].e1, tbl[i].e2);
            if (tbl[i].rd) chk("tbl_b1", b_d1, tbl[i].eb1);
        end
        chk("hold_d1", a_d1, 32'hCAFEF00D);
        idle_in();

        for (int i = 1; i < 32; i++) begin
            wr_en = 1; wa = 5'(i); wd = i;
            step(1'b0, 0, 0);
        end
        idle_in();
        rd_en = 1; a1 = 5'd3; a2 = 5'd30;
        step(1'b0, 0, 0);
        chk("fill3", a_d1, 32'd3);

        clr = 1;
        step(1'b0, 0, 0);
        clr = 0;
        rd_en = 1; a1 = 5'd3; a2 = 5'd7;
        n = 0;
        while (a_busy && n < 100) begin
            n++;
            wr_en = (n == 1);
            wa = 5'd3; wd = 32'hAA;
            step(1'b0, 0, 0);
        end
        chk("clr_len", n, 32);
        idle_in();

        for (int i = 0; i < 32; i += 2) begin
            rd_en = 1; a1 = 5'(i); a2 = 5'(i + 1);
            step(1'b0, 0, 0);
            chk("post_clr", a_d2, 32'h0);
        end
        idle_in();

        for (int i = 1; i < 6; i++) begin
            wr_en = 1; wa = 5'(i); wd = 32'h100 + i;
            step(1'b0, 0, 0);
        end
        idle_in();
        clr = 1;
        step(1'b0, 0, 0);
        clr = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 0, 0);
        #2 resetn = 1'b0;
        #1;
        chk("mid_busy", {31'd0, a_busy}, 32'h0);
        chk("mid_valid", {31'd0, a_v}, 32'h0);
        chk("mid_d1", a_d1, 32'h0);
        model_reset();
        @(posedge clock);
        #2 resetn = 1'b1;
        for (int i = 1; i < 6; i++) begin
            rd_en = 1; a1 = 5'(i); a2 = 5'(i);
            step(1'b0, 0, 0);
            chk("mid_rd", a_d1, 32'h0);
        end
        idle_in();
        wr_en = 1; wa = 5'd4; wd = 32'h5A5A5A5A;
        step(1'b0, 0, 0);
        idle_in();
        rd_en = 1; a1 = 5'd4; a2 = 5'd0;
        step(1'b0, 0, 0);
        chk("mid_wr", a_d1, 32'h5A5A5A5A);
        idle_in();

        c_wr_en = 1; c_wa = 3'd7; c_wd = 16'hBEEF;
        @(posedge clock); #1;
        c_wr_en = 0; c_rd_en = 1; c_a1 = 3'd7; c_a2 = 3'd0;
        @(posedge clock); #1;
        chk("c_rd7", {16'd0, c_d1}, 32'hBEEF);
        chk("c_rd0", {16'd0, c_d2}, 32'h0);
        chk("c_valid", {31'd0, c_v}, 32'h1);
        c_rd_en = 0; c_clr = 1;
        @(posedge clock); #1;
        c_clr = 0;
        n = 0;
        while (c_busy && n < 50) begin
            n++;
            @(posedge clock); #1;
        end
        chk("c_clr_len", n, 8);
        c_rd_en = 1; c_a1 = 3'd7; c_a2 = 3'd7;
        @(posedge clock); #1;
        chk("c_post", {16'd0, c_d1}, 32'h0);
        chk("c_post_v", {31'd0, c_v}, 32'h1);
        c_rd_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
